// File: rtl/fb_write_arbiter.sv
// Framebuffer write arbiter. Each frame starts with a clear sweep, then the block arbitrates two pixel-write requesters.
// Define FB_WRITE_ARBITER_ROUND_ROBIN_EN for round-robin grants. When it is undefined, req0 has fixed priority over req1.
module fb_write_arbiter #(
    parameter int         SCREEN_W      = 800,
    parameter int         SCREEN_H      = 600,
    parameter logic [1:0] CLEAR_PALETTE = 2'd0
) (
    input  logic        clk_33m,
    input  logic        rst,
    input  logic        frame_start,
    input  logic        req0_valid,
    input  logic [11:0] req0_x,
    input  logic [11:0] req0_y,
    input  logic [1:0]  req0_palette,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [11:0] req1_x,
    input  logic [11:0] req1_y,
    input  logic [1:0]  req1_palette,
    output logic        req1_ready,
    output logic [11:0] write_x,
    output logic [11:0] write_y,
    output logic [1:0]  write_palette,
    output logic        write_en,
    output logic        clear_busy,
    output logic        clear_done
);
    localparam logic [11:0] LAST_X = 12'(SCREEN_W - 1);
    localparam logic [11:0] LAST_Y = 12'(SCREEN_H - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, SERVE} state_t;

    state_t      state, state_nxt;
    logic [11:0] clr_x, clr_y;
    logic        clr_last;
    logic        grant0, grant1;
    logic        issue_en;
    logic [11:0] issue_x, issue_y;
    logic [1:0]  issue_palette;

`ifdef FB_WRITE_ARBITER_ROUND_ROBIN_EN
    logic rr_ptr;  // set when req1 holds priority for the next contested cycle

    always_ff @(posedge clk_33m) begin
        if (rst)             rr_ptr <= 1'b0;
        else if (req0_ready) rr_ptr <= 1'b1;
        else if (req1_ready) rr_ptr <= 1'b0;
    end

    assign grant0 = req0_valid && (!req1_valid || !rr_ptr);
`else
    assign grant0 = req0_valid;
`endif
    assign grant1   = req1_valid && !grant0;
    assign clr_last = (clr_x == LAST_X) && (clr_y == LAST_Y);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_nxt     = state;
        req0_ready    = 1'b0;
        req1_ready    = 1'b0;
        clear_busy    = 1'b0;
        clear_done    = 1'b0;
        issue_en      = 1'b0;
        issue_x       = clr_x;
        issue_y       = clr_y;
        issue_palette = CLEAR_PALETTE;
        if (!rst) begin
            unique case (state)
                IDLE: if (frame_start) state_nxt = CLEAR;
                CLEAR: begin
                    clear_busy = 1'b1;
                    issue_en   = 1'b1;
                    if (!frame_start && clr_last) begin
                        clear_done = 1'b1;
                        state_nxt  = SERVE;
                    end
                end
                SERVE: begin
                    if (frame_start) begin
                        state_nxt = CLEAR;
                    end else begin
                        req0_ready    = grant0;
                        req1_ready    = grant1;
                        issue_x       = grant0 ? req0_x : req1_x;
                        issue_y       = grant0 ? req0_y : req1_y;
                        issue_palette = grant0 ? req0_palette : req1_palette;
                        // Off-screen requests are still acknowledged but never reach the framebuffer.
                        issue_en      = (grant0 || grant1) && (issue_x <= LAST_X) && (issue_y <= LAST_Y);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk_33m) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk_33m) begin
        if (rst || state != CLEAR || frame_start) begin
            clr_x <= '0;
            clr_y <= '0;
        end else if (clr_x == LAST_X) begin
            clr_x <= '0;
            clr_y <= (clr_y == LAST_Y) ? '0 : clr_y + 12'd1;
        end else begin
            clr_x <= clr_x + 12'd1;
        end
    end

    always_ff @(posedge clk_33m) begin
        if (rst) begin
            write_en      <= 1'b0;
            write_x       <= '0;
            write_y       <= '0;
            write_palette <= '0;
        end else begin
            write_en <= issue_en;
            if (issue_en) begin
                write_x       <= issue_x;
                write_y       <= issue_y;
                write_palette <= issue_palette;
            end
        end
    end
endmodule

// File: doc/fb_write_arbiter.md
FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

Interface
REQ-001 SHALL have parameter SCREEN_W, default 800, visible pixels per line.
REQ-002 SHALL have parameter SCREEN_H, default 600, visible lines per frame.
REQ-003 SHALL have parameter CLEAR_PALETTE, default 2'd0, palette index written during clear sweep.
REQ-004 SHALL have port clk_33m  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port frame_start  input  1  one-cycle pulse per frame; starts clear sweep.
REQ-007 SHALL have ports req0_valid, req0_x, req0_y, req0_palette  input  1/12/12/2  requester 0 (painter) pixel write.
REQ-008 SHALL have port req0_ready  output  1  requester 0 accepted this cycle.
REQ-009 SHALL have ports req1_valid, req1_x, req1_y, req1_palette  input  1/12/12/2  requester 1 (HUD overlay) pixel write.
REQ-010 SHALL have port req1_ready  output  1  requester 1 accepted this cycle.
REQ-011 SHALL have ports write_x, write_y, write_palette, write_en  output  12/12/2/1  registered framebuffer write port.
REQ-012 SHALL have port clear_busy  output  1  high while clear sweep runs.
REQ-013 SHALL have port clear_done  output  1  one-cycle pulse on last clear pixel issue.

Function
REQ-014 SHALL implement states IDLE, CLEAR, SERVE.
REQ-015 IDLE: both readies 0, write_en 0; frame_start -> CLEAR.
REQ-016 CLEAR: issue one pixel per cycle, x 0..SCREEN_W-1 inner, y 0..SCREEN_H-1 outer, palette CLEAR_PALETTE, write_en 1; readies 0; clear_busy 1.
REQ-017 CLEAR: after issuing (SCREEN_W-1, SCREEN_H-1), pulse clear_done in that same cycle and enter SERVE next cycle; sweep takes exactly SCREEN_W*SCREEN_H cycles.
REQ-018 frame_start during CLEAR SHALL restart the sweep at (0,0) next cycle; no clear_done from the aborted sweep.
REQ-019 frame_start during SERVE SHALL force both readies 0 that cycle and enter CLEAR next cycle.
REQ-020 SERVE: at most one grant per cycle; reqN_ready combinational, high only when reqN_valid and reqN granted.
REQ-021 A handshake (valid && ready) SHALL produce write_x/y/palette = request fields and write_en 1 exactly one cycle later.
REQ-022 Granted requests with x >= SCREEN_W or y >= SCREEN_H SHALL be accepted (ready 1) but dropped (write_en 0 next cycle).
REQ-023 Cycles without issue SHALL drive write_en 0; write_x/y/palette hold last value.
REQ-024 Requester fields SHALL be sampled only on handshake; valid without ready holds no state in this block.
REQ-025 Clear counters SHALL be 12 bits; x wraps to 0 with y increment at SCREEN_W-1.

Reset
REQ-026 rst SHALL force state IDLE, clear counters 0, RR pointer 0.
REQ-027 rst SHALL force write_x, write_y, write_palette, write_en, clear_busy, clear_done to 0; readies 0 during rst.
REQ-028 rst asserted mid-CLEAR or mid-SERVE SHALL abandon the operation with no further writes; rst dominates simultaneous frame_start.

Configuration
REQ-029 Macro FB_WRITE_ARBITER_ROUND_ROBIN_EN SHALL select the SERVE grant policy.
REQ-030 Undefined: fixed priority, req0 over req1 whenever both valid.
REQ-031 Defined: round-robin; after a handshake with requester N, the other requester gets priority next; a lone valid requester is always granted.

Verification
REQ-032 rst, then frame_start with SCREEN_W=4, SCREEN_H=3 -> 12 consecutive write_en cycles (0,0)..(3,2) palette 0, clear_done on 12th issue, SERVE next cycle.
REQ-033 SERVE, req0 and req1 valid continuously, macro undefined -> req0_ready every cycle, req1_ready never; writes at req0 coordinates with 1-cycle latency.
REQ-034 Same stimulus, macro defined -> grants alternate req0, req1, req0, ...; write stream interleaves accordingly.
REQ-035 SERVE, req1 (x=4, y=0) with SCREEN_W=4 -> req1_ready 1, next cycle write_en 0.
REQ-036 frame_start at clear pixel (2,1), then again during SERVE with req0 valid -> sweep restarts at (0,0), single clear_done; req0_ready 0 in frame_start cycle, CLEAR next.
REQ-037 rst during CLEAR at pixel (1,1) -> next cycle write_en 0, clear_busy 0, state IDLE; readies stay 0 until frame_start and a full sweep.
